// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: funct3 widths, FSM states,
// the debug view and the request legality helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    typedef struct packed {
        state_t state;
        logic   addr_beyond_depth;
    } dbg_t;

    // Unsigned widths exist only for loads; 011 and 11x are never legal.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (is_store && f3[2]);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3 == F3_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Core-side request/response and memory-side bus of the load/store sequencer.
// req is a valid with no ready: it is taken at a clock edge only while busy=0;
// each accepted req yields exactly one done pulse (with err on rejection).
interface mem_access_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wren, mem_wdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wren, mem_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: merges sub-word store data into a read word and
// extracts/extends sub-word load data.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  lane,
    input  logic [31:0] st_word,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] st_merged,
    output logic [31:0] ld_ext
);
    logic [3:0]  be;
    logic [31:0] ins;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        be  = 4'b1111;
        ins = st_data;
        case (f3[1:0])
            2'b00: begin
                be  = 4'b0001 << lane;
                ins = {4{st_data[7:0]}};
            end
            2'b01: begin
                be  = lane[1] ? 4'b1100 : 4'b0011;
                ins = {2{st_data[15:0]}};
            end
            default: begin
                be  = 4'b1111;
                ins = st_data;
            end
        endcase
    end

    always_comb begin
        st_merged = st_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) st_merged[8*i +: 8] = ins[8*i +: 8];
        end
    end

    always_comb begin
        ld_b   = ld_word[{lane, 3'b000} +: 8];
        ld_h   = lane[1] ? ld_word[31:16] : ld_word[15:0];
        ld_ext = ld_word;
        case (f3)
            F3_B:    ld_ext = {{24{ld_b[7]}}, ld_b};
            F3_BU:   ld_ext = {24'h0, ld_b};
            F3_H:    ld_ext = {{16{ld_h[15]}}, ld_h};
            F3_HU:   ld_ext = {16'h0, ld_h};
            default: ld_ext = ld_word;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer adding byte/halfword access over a word memory.
// Define MEM_BOUNDS_CHECK_EN to reject requests with word index >= DEPTH.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus,
    output dbg_t         dbg
);
    state_t      state, state_nxt;
    logic [31:0] a_q, wd_q, word_q, rdata_q, ld_ext, st_merged;
    logic [2:0]  f3_q;
    logic        we_q, oob, bad_req;

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = (bus.addr[31:2] >= 30'(DEPTH));
`else
    assign oob = 1'b0;
`endif

    assign bad_req = f3_illegal(bus.funct3, bus.we) || misaligned(bus.funct3, bus.addr[1:0]) || oob;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad_req)                          state_nxt = ERR;
                    else if (bus.we && bus.funct3 == F3_W) state_nxt = WR;
                    else                                  state_nxt = RD;
                end
            end
            RD:      state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write enable comes from the state register alone so reset kills it at once.
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.done     = (state == RESP) || (state == ERR);
        bus.err      = (state == ERR);
        bus.mem_wren = (state == WR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            wd_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                a_q  <= bus.addr;
                wd_q <= bus.wdata;
                f3_q <= bus.funct3;
                we_q <= bus.we;
            end
            if (state == RD) begin
                word_q <= bus.mem_rdata;
                if (!we_q) rdata_q <= ld_ext;
            end
        end
    end

    mem_lane_align u_align (
        .f3        (f3_q),
        .lane      (a_q[1:0]),
        .st_word   (word_q),
        .st_data   (wd_q),
        .ld_word   (bus.mem_rdata),
        .st_merged (st_merged),
        .ld_ext    (ld_ext)
    );

    assign bus.mem_addr  = {a_q[31:2], 2'b00};
    assign bus.mem_wdata = st_merged;
    assign bus.rdata     = rdata_q;

    assign dbg.state             = state;
    assign dbg.addr_beyond_depth = (a_q[31:2] >= 30'(DEPTH));
endmodule
